// File: rtl/uart_tx_fifo_if.sv
// Byte producer handshake into the UART transmit queue: data + valid forward, ready back.
`timescale 1ns/1ps
interface uart_tx_fifo_if;
    logic [7:0] Tx_Parallel;
    logic       Tx_Valid;
    logic       Tx_Ready;

    modport master (output Tx_Parallel, output Tx_Valid, input  Tx_Ready);
    modport slave  (input  Tx_Parallel, input  Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte accepted at E0 into an idle, empty queue drives the start bit from E1.
// Backpressure: Tx_Ready drops while the queue is full; a push while full is dropped and flagged on Overflow.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int clks_per_bit = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  tx,
    output logic           Tx_Serial,
    output logic           Busy,
    output logic [3:0]     Count,
    output logic           Overflow
);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = $clog2(clks_per_bit);
    localparam logic [3:0]     DEPTH_C = 4'(FIFO_DEPTH);
    localparam logic [CW-1:0]  LAST_C  = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0]  CNT1_C  = CW'(1);
    localparam logic [AW-1:0]  PTR1_C  = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [3:0]      count_q, count_d;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q, ovf_q;
    logic            push, pop, bit_end;

    assign tx.Tx_Ready = (count_q != DEPTH_C);
    assign push        = tx.Tx_Valid & tx.Tx_Ready;
    assign bit_end     = (clk_cnt_q == LAST_C);
    // Pop from IDLE, or on the last stop cycle so the next start bit follows with no gap.
    assign pop         = (count_q != 4'd0) &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 4'd1;
        else if (!push && pop)
            count_d = count_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= tx.Tx_Parallel;
                wptr_q        <= wptr_q + PTR1_C;
            end
            if (pop)
                rptr_q <= rptr_q + PTR1_C;
            count_q <= count_d;
            ovf_q   <= tx.Tx_Valid & ~tx.Tx_Ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    clk_cnt_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT1_C;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT1_C;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rptr_q];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT1_C;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Tx_Serial = tx_q;
    assign Count     = count_q;
    assign Overflow  = ovf_q;
    assign Busy      = (state_q != IDLE) || (count_q != 4'd0);
endmodule
